x595_serial_driver: RTL and testbench
=====================================

# x595_serial_driver

- Upstream driver for one x74xx595 serial-to-parallel register or a cascade of them.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB first on SER/SRCLK.
- Pulses RCLK to transfer the word to the output latches, and provides shift-register clear and output-enable control.
- Its outputs connect pin-for-pin to the x74xx595 inputs, so software-visible bytes appear on the parallel QA–QH pins.

## Interface
Parameters:
- NUM_CHIPS, 1 — number of cascaded 595s; data width W = 8*NUM_CHIPS.
- DIV, 1 — system clocks per phase (SRCLK low, SRCLK high, RCLK high, SRCLR_N low); must be ≥1.

Ports (one clock, `clock_50`; reset is asynchronous and active-high):
- clock_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  word offered.
- in_ready  out  1  driver idle and able to accept.
- in_data  in  W  word; bit W-1 is shifted first and lands in QH of the last chip.
- clear_req  in  1  request a shift-register clear pulse.
- oe_enable  in  1  1 = enable 595 outputs.
- busy  out  1  transfer or clear in progress.
- SER  out  1  serial data.
- SRCLK  out  1  shift clock.
- RCLK  out  1  latch clock.
- SRCLR_N  out  1  shift-register clear, active low.
- OE_N  out  1  output enable, active low.

## Operation
FSM states: IDLE, SETUP, SCLK_HI, LATCH, CLEAR. Counters: phase divider (0..DIV-1) and bit counter (0..W-1).

- **IDLE**
  - in_ready=1, busy=0.
  - clear_req has priority over in_valid.
  - If clear_req: go to CLEAR.
  - Else if in_valid: load shift register from in_data, set bit counter = W-1, set SER = in_data[W-1], go to SETUP.
- **SETUP**
  - SRCLK=0; SER stable.
  - After DIV cycles, go to SCLK_HI.
- **SCLK_HI**
  - SRCLK=1; SER unchanged.
  - After DIV cycles:
    - If bit counter == 0: go to LATCH.
    - Else: shift the shift register left by 1, decrement the bit counter, drive SER = new MSB, go to SETUP.
- **LATCH**
  - RCLK=1 for DIV cycles, then return to IDLE.
- **CLEAR**
  - SRCLR_N=0 for DIV cycles, then return to IDLE.
  - The 595 output latches are untouched.

Signal rules:
- SER changes only on the SCLK_HI→SETUP edge or on acceptance. It holds its last value in LATCH and IDLE.
- OE_N is a register copy of ~oe_enable, updated every cycle regardless of state.
- in_valid and clear_req are ignored outside IDLE; no queuing.
- in_data is captured only on the accept edge, so later changes have no effect.

## Timing
- Every output is registered (glitch-free to the board). in_ready and busy decode from the state register.
- Reset values:
  - SER=0, SRCLK=0, RCLK=0, SRCLR_N=1, OE_N=1 (outputs tristated).
  - State IDLE, so in_ready=1 and busy=0.
- Transfer timing, counted from the accept edge:
  - SRCLK rises DIV cycles after the accept edge.
  - The k-th rise (k=0..W-1) is at cycle (2k+1)·DIV.
  - RCLK rises at 2W·DIV and falls at (2W+1)·DIV.
  - in_ready reasserts at cycle (2W+1)·DIV.
  - W=8, DIV=1: 17 cycles.
- Clear: SRCLR_N is low for exactly DIV cycles; in_ready returns DIV cycles after acceptance.
- Back-to-back transfers: a new word can be accepted on the first cycle in_ready is 1; no dead cycle.
- Reset asserted mid-transfer:
  - All outputs return to reset values immediately.
  - The partially shifted word is discarded.
  - No RCLK pulse occurs, so 595 output latches keep their previous value.
- oe_enable toggling mid-transfer affects only OE_N, one cycle later.

## Structure
- Package `x595_driver_pkg`: state enum (IDLE, SETUP, SCLK_HI, LATCH, CLEAR) and a width-computation function for counters ($clog2 of W and DIV, minimum 1 bit).
- Sub-module `x595_phase_timer`: a DIV-cycle down-counter.
  - Inputs: load, clock, reset.
  - Output: `done` pulse.
  - Instantiated once and reused by all timed states.

## Test plan
Bench: x595_serial_driver drives an x74xx595 chain.
- Reset then release; check all reset values; assert clear_req for 1 cycle → SRCLR_N low exactly DIV cycles, QH_L = 0.
- NUM_CHIPS=1, DIV=1:
  - Send 8'hA5 → QA..QH = 1,0,1,0,0,1,0,1 after RCLK.
  - in_ready low for exactly 17 cycles.
  - 8 SRCLK rises, 1 RCLK pulse.
- Back-to-back 8'h55 then 8'hFF with in_valid held high → second accept on the in_ready return cycle; outputs 8'h55 then 8'hFF.
- DIV=3, NUM_CHIPS=2:
  - Send 16'h1234 → chip0 = 8'h34, chip1 = 8'h12.
  - SRCLK high/low phases each 3 cycles.
  - in_ready returns at cycle 99.
- Assert reset at cycle 6 of a transfer of 8'h0F after 8'hF0 was latched → outputs stay 8'hF0, SRCLK=0, in_ready=1 after release.
- Assert clear_req and in_valid together in IDLE → CLEAR taken first, word accepted afterwards. oe_enable=0 → QA..QH read Z.

Source files
------------

// File: rtl/x595_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : x595_driver_pkg
//  Purpose  : Shared state encoding and counter sizing for the x595 driver.
//  Revision : 1.0
// ============================================================================
package x595_driver_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SCLK_HI = 3'd2,
        LATCH   = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/x595_serial_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : x595_serial_driver_if
//  Purpose  : Upstream word handshake and control bundle for the x595 driver.
//  Revision : 1.0
// ============================================================================
interface x595_serial_driver_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         clear_req;
    logic         oe_enable;
    logic         busy;

    modport master (
        output in_valid, in_data, clear_req, oe_enable,
        input  in_ready, busy
    );

    modport slave (
        input  in_valid, in_data, clear_req, oe_enable,
        output in_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/x595_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : x595_phase_timer
//  Purpose  : DIV-cycle down-counter; done marks the last cycle of a phase.
//  Revision : 1.0
// ============================================================================
module x595_phase_timer
    import x595_driver_pkg::*;
#(
    parameter int DIV = 1
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_load,
    output logic o_done
);
    localparam int               c_cw     = cnt_width(DIV);
    localparam logic [c_cw-1:0]  c_reload = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_reload;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/x595_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module   : x595_serial_driver
//  Purpose  : Shifts a parallel word MSB first into a 74xx595 cascade and
//             latches it; also drives shift-register clear and output enable.
//  Revision : 1.0
// ============================================================================
module x595_serial_driver
    import x595_driver_pkg::*;
#(
    parameter int NUM_CHIPS = 1,
    parameter int DIV       = 1
) (
    input  wire                 clock_50,
    input  wire                 reset,
    x595_serial_driver_if.slave bus,
    output logic                SER,
    output logic                SRCLK,
    output logic                RCLK,
    output logic                SRCLR_N,
    output logic                OE_N
);
    localparam int              c_w        = 8 * NUM_CHIPS;
    localparam int              c_bw       = cnt_width(c_w);
    localparam logic [c_bw-1:0] c_last_bit = c_bw'(c_w - 1);

    state_t          r_state;
    // Holds only the bits not yet on SER; the current bit lives in r_ser.
    logic [c_w-2:0]  r_shift;
    logic [c_bw-1:0] r_bit_cnt;
    logic            r_ser;
    logic            r_srclk;
    logic            r_rclk;
    logic            r_srclr_n;
    logic            r_oe_n;
    logic            w_timer_load;
    logic            w_phase_done;

    // Every state entry restarts the phase timer, including entry from IDLE.
    always_comb begin
        w_timer_load = 1'b0;
        if (r_state == IDLE) begin
            w_timer_load = bus.clear_req | bus.in_valid;
        end else begin
            w_timer_load = w_phase_done;
        end
    end

    x595_phase_timer #(
        .DIV (DIV)
    ) u_phase_timer (
        .clk    (clock_50),
        .rst    (reset),
        .i_load (w_timer_load),
        .o_done (w_phase_done)
    );

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ser     <= 1'b0;
            r_srclk   <= 1'b0;
            r_rclk    <= 1'b0;
            r_srclr_n <= 1'b1;
            r_oe_n    <= 1'b1;
        end else begin
            r_oe_n <= ~bus.oe_enable;
            case (r_state)
                IDLE: begin
                    if (bus.clear_req) begin
                        r_srclr_n <= 1'b0;
                        r_state   <= CLEAR;
                    end else if (bus.in_valid) begin
                        r_shift   <= bus.in_data[c_w-2:0];
                        r_ser     <= bus.in_data[c_w-1];
                        r_bit_cnt <= c_last_bit;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_phase_done) begin
                        r_srclk <= 1'b1;
                        r_state <= SCLK_HI;
                    end
                end
                SCLK_HI: begin
                    if (w_phase_done) begin
                        r_srclk <= 1'b0;
                        if (r_bit_cnt == '0) begin
                            r_rclk  <= 1'b1;
                            r_state <= LATCH;
                        end else begin
                            r_ser     <= r_shift[c_w-2];
                            r_shift   <= {r_shift[c_w-3:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            r_state   <= SETUP;
                        end
                    end
                end
                LATCH: begin
                    if (w_phase_done) begin
                        r_rclk  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (w_phase_done) begin
                        r_srclr_n <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (r_state == IDLE);
    assign bus.busy     = (r_state != IDLE);
    assign SER          = r_ser;
    assign SRCLK        = r_srclk;
    assign RCLK         = r_rclk;
    assign SRCLR_N      = r_srclr_n;
    assign OE_N         = r_oe_n;

endmodule
`default_nettype wire

// File: tb/tb_x595_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x595_serial_driver
//  Purpose  : Two drivers (1 chip/DIV=1 and 2 chips/DIV=3) feeding 595 chain
//             models, checked against a waveform model built from timing rules.
//  Revision : 1.0
// ============================================================================
module tb_x595_serial_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        in_valid  [2];
    logic        clear_req [2];
    logic        oe_enable [2];
    logic [15:0] in_data   [2];
    logic        cmp_en = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;

    x595_serial_driver_if #(.W(8))  bus0 ();
    x595_serial_driver_if #(.W(16)) bus1 ();

    assign bus0.in_valid  = in_valid[0];
    assign bus0.in_data   = in_data[0][7:0];
    assign bus0.clear_req = clear_req[0];
    assign bus0.oe_enable = oe_enable[0];
    assign bus1.in_valid  = in_valid[1];
    assign bus1.in_data   = in_data[1];
    assign bus1.clear_req = clear_req[1];
    assign bus1.oe_enable = oe_enable[1];

    wire ser0, srclk0, rclk0, srclr_n0, oe_n0;
    wire ser1, srclk1, rclk1, srclr_n1, oe_n1;

    x595_serial_driver #(.NUM_CHIPS(1), .DIV(1)) dut0 (
        .clock_50 (clk),   .reset (rst[0]), .bus (bus0),
        .SER (ser0), .SRCLK (srclk0), .RCLK (rclk0), .SRCLR_N (srclr_n0), .OE_N (oe_n0)
    );

    x595_serial_driver #(.NUM_CHIPS(2), .DIV(3)) dut1 (
        .clock_50 (clk),   .reset (rst[1]), .bus (bus1),
        .SER (ser1), .SRCLK (srclk1), .RCLK (rclk1), .SRCLR_N (srclr_n1), .OE_N (oe_n1)
    );

    // 74xx595 chain models: shift on SRCLK rise, async clear, latch on RCLK rise.
    logic [7:0]  sr0, q0;
    logic [15:0] sr1, q1;
    int srise0 = 0, srise1 = 0, rrise0 = 0, rrise1 = 0;

    always @(posedge srclk0 or negedge srclr_n0)
        if (!srclr_n0) sr0 <= '0;
        else begin sr0 <= {sr0[6:0], ser0}; srise0++; end
    always @(posedge srclk1 or negedge srclr_n1)
        if (!srclr_n1) sr1 <= '0;
        else begin sr1 <= {sr1[14:0], ser1}; srise1++; end
    always @(posedge rclk0) begin q0 <= sr0; rrise0++; end
    always @(posedge rclk1) begin q1 <= sr1; rrise1++; end

    function automatic int wid(input int k); return 8 * (k + 1); endfunction
    function automatic int dv(input int k);  return (k == 0) ? 1 : 3; endfunction

    function automatic logic [6:0] outs(input int k);
        if (k == 0) return {ser0, srclk0, rclk0, srclr_n0, oe_n0, bus0.in_ready, bus0.busy};
        return {ser1, srclk1, rclk1, srclr_n1, oe_n1, bus1.in_ready, bus1.busy};
    endfunction
    function automatic logic rdy(input int k);
        return (k == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction
    function automatic logic srclk_of(input int k);
        return (k == 0) ? srclk0 : srclk1;
    endfunction
    function automatic logic srclr_of(input int k);
        return (k == 0) ? srclr_n0 : srclr_n1;
    endfunction
    function automatic logic [15:0] qpar(input int k);
        return (k == 0) ? {8'h00, q0} : q1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Waveform model: mode 0 idle, 1 transfer, 2 clear; t counts edges since acceptance.
    int          m_mode [2];
    int          m_t    [2];
    logic [15:0] m_word [2];
    logic        m_ser  [2];
    logic        m_oe_n [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_mode[k] = 0; m_t[k] = 0; m_ser[k] = 1'b0; m_oe_n[k] = 1'b1;
            end else begin
                m_oe_n[k] = ~oe_enable[k];
                if (m_mode[k] == 0) begin
                    if (clear_req[k]) begin
                        m_mode[k] = 2; m_t[k] = 0;
                    end else if (in_valid[k]) begin
                        m_mode[k] = 1; m_t[k] = 0; m_word[k] = in_data[k];
                    end
                end else begin
                    m_t[k]++;
                    if ((m_mode[k] == 1 && m_t[k] == (2 * wid(k) + 1) * dv(k)) ||
                        (m_mode[k] == 2 && m_t[k] == dv(k)))
                        m_mode[k] = 0;
                end
                if (m_mode[k] == 1 && m_t[k] < 2 * wid(k) * dv(k))
                    m_ser[k] = m_word[k][wid(k) - 1 - m_t[k] / (2 * dv(k))];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                logic       xf, sh;
                logic [6:0] e;
                xf = (m_mode[k] == 1);
                sh = xf && (m_t[k] < 2 * wid(k) * dv(k));
                e  = {m_ser[k], sh && ((m_t[k] / dv(k)) % 2 == 1), xf && !sh,
                      m_mode[k] != 2, m_oe_n[k], m_mode[k] == 0, m_mode[k] != 0};
                check($sformatf("pins_dut%0d_t%0d", k, m_t[k]), outs(k), e);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ready(input int k, output int cyc);
        cyc = 0;
        while (!rdy(k) && cyc < 400) begin cyc++; step(); end
        check($sformatf("ready_return_dut%0d", k), rdy(k), 1'b1);
    endtask

    task automatic send(input int k, input logic [15:0] w, input int flip_at,
                        input int noise_at, output int lc, output int hi);
        in_data[k]  = w;
        in_valid[k] = 1'b1;
        step();
        in_valid[k] = 1'b0;
        in_data[k]  = ~w;
        lc = 0;
        hi = 0;
        while (!rdy(k) && lc < 400) begin
            lc++;
            if (srclk_of(k)) hi++;
            clear_req[k] = (lc == noise_at);
            if (lc == flip_at) oe_enable[k] = ~oe_enable[k];
            step();
        end
        clear_req[k] = 1'b0;
        check($sformatf("xfer_done_dut%0d", k), rdy(k), 1'b1);
    endtask

    task automatic do_clear(input int k, output int low);
        clear_req[k] = 1'b1;
        step();
        clear_req[k] = 1'b0;
        low = 0;
        while (!srclr_of(k) && low < 100) begin low++; step(); end
        check($sformatf("clear_ready_dut%0d", k), rdy(k), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int lc, hi, s0, r0, nend;
        logic [15:0] w;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; in_valid[k] = 1'b0; clear_req[k] = 1'b0;
            oe_enable[k] = 1'b0; in_data[k] = '0;
            m_mode[k] = 0; m_t[k] = 0; m_word[k] = '0; m_ser[k] = 1'b0; m_oe_n[k] = 1'b1;
        end
        #2;
        rst[0] = 1'b1; rst[1] = 1'b1;
        step(); step();
        cmp_en = 1'b1;
        check("reset_outs_dut0", outs(0), 7'b0001110);
        check("reset_outs_dut1", outs(1), 7'b0001110);
        rst[0] = 1'b0; rst[1] = 1'b0;
        oe_enable[0] = 1'b1; oe_enable[1] = 1'b1;
        step(); step();
        check("oe_on", {oe_n0, oe_n1}, 2'b00);

        // Single 8-bit transfer at DIV=1
        s0 = srise0; r0 = rrise0;
        send(0, 16'h00A5, -1, -1, lc, hi);
        check("a5_ready_low_cycles", lc, 17);
        check("a5_latched", q0, 8'hA5);
        check("a5_qa_qh", {q0[0], q0[1], q0[2], q0[3], q0[4], q0[5], q0[6], q0[7]}, 8'b10100101);
        check("a5_srclk_rises", srise0 - s0, 8);
        check("a5_rclk_pulses", rrise0 - r0, 1);
        check("a5_srclk_high_cycles", hi, 8);

        // Clear pulses: length DIV, latches untouched
        do_clear(0, lc);
        check("clear_low_dut0", lc, 1);
        check("clear_qh_serial", sr0[7], 1'b0);
        check("clear_keeps_latch", q0, 8'hA5);
        do_clear(1, lc);
        check("clear_low_dut1", lc, 3);
        check("clear_sr_dut1", sr1, 16'h0000);

        // Back-to-back with in_valid held
        in_data[0] = 16'h0055; in_valid[0] = 1'b1;
        step();
        in_data[0] = 16'h00FF;
        wait_ready(0, lc);
        check("b2b_first_word", q0, 8'h55);
        step();
        check("b2b_no_dead_cycle", rdy(0), 1'b0);
        in_valid[0] = 1'b0;
        wait_ready(0, lc);
        check("b2b_second_word", q0, 8'hFF);

        // Two chips at DIV=3
        send(1, 16'h1234, -1, -1, lc, hi);
        check("w16_ready_low_cycles", lc, 99);
        check("w16_chip0", q1[7:0], 8'h34);
        check("w16_chip1", q1[15:8], 8'h12);
        check("w16_srclk_high_cycles", hi, 48);

        // Reset mid-transfer keeps previously latched byte
        send(0, 16'h00F0, -1, -1, lc, hi);
        check("pre_reset_latch", q0, 8'hF0);
        r0 = rrise0;
        in_data[0] = 16'h000F; in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        repeat (5) step();
        rst[0] = 1'b1;
        #1;
        check("reset_immediate_outs", outs(0), 7'b0001110);
        step();
        rst[0] = 1'b0;
        step();
        check("reset_ready", rdy(0), 1'b1);
        check("reset_srclk_low", srclk0, 1'b0);
        check("reset_latch_kept", q0, 8'hF0);
        check("reset_no_rclk", rrise0 - r0, 0);

        // clear_req and in_valid together: clear first, word afterwards
        clear_req[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 16'h00C3;
        step();
        check("both_clear_first", srclr_n0, 1'b0);
        clear_req[0] = 1'b0;
        step();
        check("both_idle_after_clear", rdy(0), 1'b1);
        step();
        in_valid[0] = 1'b0;
        check("both_word_accepted", rdy(0), 1'b0);
        wait_ready(0, lc);
        check("both_word_latched", q0, 8'hC3);

        // Output enable off one cycle later
        oe_enable[0] = 1'b0;
        step();
        check("oe_off_tristate", oe_n0, 1'b1);
        oe_enable[0] = 1'b1;
        step();

        // Randomized traffic with mid-transfer noise on clear_req and oe_enable
        for (int i = 0; i < 24; i++) begin
            int k, op, flip, noise;
            k  = $urandom_range(0, 1);
            op = $urandom_range(0, 5);
            if (op == 0) begin
                do_clear(k, lc);
                check("rnd_clear_len", lc, dv(k));
            end else begin
                w = 16'($urandom);
                if (k == 0) w[15:8] = 8'h00;
                nend  = (2 * wid(k) + 1) * dv(k);
                flip  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nend - 1)) : -1;
                noise = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nend - 2)) : -1;
                send(k, w, flip, noise, lc, hi);
                check("rnd_ready_low_cycles", lc, nend);
                check("rnd_word_latched", qpar(k), w);
                check("rnd_srclk_high_cycles", hi, wid(k) * dv(k));
            end
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
